// File: rtl/mul_hs_pkg.sv
// Shared definitions for the handshaked multipliers and their result buffer.
package mul_hs_pkg;
  localparam int MUL_W_DEF = 256;
  localparam int MUL_K_DEF = 1;

  // Pointer/count width: one extra wrap bit above the index bits.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/mul_result_fifo_if.sv
// Handshake bundle between the multiplier output, the result FIFO and its consumer.
interface mul_result_fifo_if
  import mul_hs_pkg::*;
#(
  parameter int W     = MUL_W_DEF,
  parameter int K     = MUL_K_DEF,
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  logic [2*W-1:0] i;
  logic [K-1:0]   ikey;
  logic           ival;
  logic           irdy;
  logic [2*W-1:0] o;
  logic [K-1:0]   okey;
  logic           oval;
  logic           ordy;
  logic [CW-1:0]  ocount;

  modport slave  (input  i, ikey, ival, ordy, output irdy, o, okey, oval, ocount);
  modport master (output i, ikey, ival, ordy, input  irdy, o, okey, oval, ocount);
endinterface

// File: rtl/mul_fifo_ram.sv
// Storage for the result FIFO: registered write port, asynchronous read port, no reset.
module mul_fifo_ram #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mul_result_fifo.sv
// First-word-fall-through buffer for {product, key} beats leaving the multipliers.
// Optional same-cycle pass-through when empty: MUL_RESULT_FIFO_BYPASS_EN.
module mul_result_fifo
  import mul_hs_pkg::*;
#(
  parameter int W     = MUL_W_DEF,
  parameter int K     = MUL_K_DEF,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  mul_result_fifo_if.slave bus
);
  localparam int CW = cnt_w(DEPTH);
  localparam int AW = CW - 1;

  typedef struct packed {
    logic [2*W-1:0] p;
    logic [K-1:0]   k;
  } entry_t;

  logic [CW-1:0] r_wptr, r_rptr;
  logic          r_irdy;
  logic [CW-1:0] w_count, w_count_nxt;
  logic          w_byp, w_wr, w_rd;
  entry_t        w_wdata, w_rdata;

  // Pointer difference is the occupancy; the wrap bit lets it reach DEPTH.
  assign w_count = r_wptr - r_rptr;

`ifdef MUL_RESULT_FIFO_BYPASS_EN
  assign w_byp = r_irdy && (w_count == '0) && bus.ordy;
`else
  assign w_byp = 1'b0;
`endif

  assign w_wr        = bus.ival && r_irdy && !w_byp;
  assign w_rd        = (w_count != '0) && bus.ordy;
  assign w_count_nxt = w_count + CW'(w_wr) - CW'(w_rd);

  always_ff @(posedge clk) begin
    if (srst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_irdy <= 1'b0;
    end else begin
      r_wptr <= r_wptr + CW'(w_wr);
      r_rptr <= r_rptr + CW'(w_rd);
      r_irdy <= (w_count_nxt != CW'(DEPTH));
    end
  end

  assign w_wdata.p = bus.i;
  assign w_wdata.k = bus.ikey;

  mul_fifo_ram #(.DW($bits(entry_t)), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr),
    .i_waddr (r_wptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign bus.irdy   = r_irdy;
  assign bus.ocount = w_count;
`ifdef MUL_RESULT_FIFO_BYPASS_EN
  assign bus.oval = w_byp ? bus.ival : (w_count != '0);
  assign bus.o    = w_byp ? bus.i    : w_rdata.p;
  assign bus.okey = w_byp ? bus.ikey : w_rdata.k;
`else
  assign bus.oval = (w_count != '0);
  assign bus.o    = w_rdata.p;
  assign bus.okey = w_rdata.k;
`endif

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (srst)
    (bus.ival && !r_irdy) |=> ($stable(bus.i) && $stable(bus.ikey)));
  a_count_max: assert property (@(posedge clk) disable iff (srst)
    (w_count <= CW'(DEPTH)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (srst)
    !(w_rd && (w_count == '0)));
`endif
endmodule
